iob_mem_arbiter_2x1: RTL and testbench
======================================

Name: iob_mem_arbiter_2x1

Overview:
Round-robin arbiter that shares one IOb-native memory port between two requesters, e.g. the SoC instruction and data buses in front of the PS-DDR bridge in the Zybo-Z7 wrapper. It allows one transaction in flight at a time. It routes read responses back to the owning requester. A watchdog completes reads that never return and flags the fault.

Parameters:
ADDR_W, 32, address width of all ports.
DATA_W, 32, data width; wstrb width is DATA_W/8.
TIMEOUT_W, 8, watchdog counter width; timeout fires after 2^TIMEOUT_W-1 cycles in WAIT_RD.
ERR_DATA, 32'hDEADBEEF, rdata returned on timeout (truncated or zero-extended to DATA_W).

Ports:
clk_i  in  1  clock.
arstn_i  in  1  asynchronous reset, active-low.
cke_i  in  1  clock enable; low freezes all state.
m{0,1}_iob_valid_i  in  1  request valid; must be held until ready.
m{0,1}_iob_addr_i  in  ADDR_W  request address.
m{0,1}_iob_wdata_i  in  DATA_W  write data.
m{0,1}_iob_wstrb_i  in  DATA_W/8  byte strobes; all-zero means read.
m{0,1}_iob_ready_o  out  1  request accepted.
m{0,1}_iob_rvalid_o  out  1  read data valid.
m{0,1}_iob_rdata_o  out  DATA_W  read data.
s_iob_valid_o  out  1  request to shared port.
s_iob_addr_o / s_iob_wdata_o / s_iob_wstrb_o  out  ADDR_W / DATA_W / DATA_W/8  forwarded request.
s_iob_ready_i  in  1  shared port accepts request.
s_iob_rvalid_i  in  1  shared port read data valid.
s_iob_rdata_i  in  DATA_W  shared port read data.
busy_o  out  1  state != IDLE.
timeout_o  out  1  one-cycle pulse on watchdog completion.

Behaviour:
- Reset (arstn_i low, async):
  - state=IDLE, grant=0, last_grant=1 (so m0 has first priority), counter=0.
  - All outputs 0.
- States: IDLE, REQ, WAIT_RD. Registers: grant, last_grant, counter.
- IDLE:
  - If any m*_valid_i: grant = the sole requester; if both are valid, grant = !last_grant. Next state REQ.
  - Arbitration costs 1 cycle: s_iob_valid_o is never asserted in IDLE.
- REQ:
  - s_iob_valid_o = m[grant]_valid_i; addr/wdata/wstrb are muxed from m[grant] (combinational).
  - m[grant]_ready_o = s_iob_ready_i; the other requester's ready_o = 0.
  - On s_valid&&s_ready with wstrb!=0 (write): next state IDLE, last_grant=grant.
  - On s_valid&&s_ready with wstrb==0 (read): next state WAIT_RD, counter=0.
  - If m[grant]_valid_i drops before acceptance (protocol violation): next state IDLE, last_grant unchanged.
- WAIT_RD:
  - m[grant]_rvalid_o = s_iob_rvalid_i; m[grant]_rdata_o = s_iob_rdata_i (same cycle).
  - On s_iob_rvalid_i: next state IDLE, last_grant=grant.
  - Otherwise counter increments. When counter == 2^TIMEOUT_W-1 and rvalid is low: m[grant]_rvalid_o=1, rdata=ERR_DATA, timeout_o=1 for that cycle; next state IDLE, last_grant=grant.
  - Real rvalid in the same cycle as expiry wins: timeout_o=0, real data returned.
- Non-granted requester: rvalid_o=0 and rdata_o=0 always; rdata is gated, never leaked.
- s_iob_rvalid_i outside WAIT_RD is ignored and not forwarded. A late response after a timeout is therefore dropped. Timeout is a fatal-fault indicator; recovery is by reset.
- cke_i low:
  - State, grant, last_grant and counter hold.
  - s_iob_valid_o, all ready_o, all rvalid_o and timeout_o forced to 0.
- Throughput: minimum 2 cycles per write (IDLE + REQ), 3 cycles per read (IDLE + REQ + WAIT_RD) with zero slave latency.
- Requester valid asserted during WAIT_RD waits; it is arbitrated on the next IDLE.

Test Plan:
1. m0 write addr 0x100, wdata 0xA5A5A5A5, wstrb 0xF, s_ready tied 1 -> s_valid_o and m0_ready_o high exactly in the cycle after m0_valid rises; s_addr_o=0x100; m1_ready_o=0; busy_o returns to 0 the next cycle.
2. m0 and m1 issue reads in the same cycle after reset, slave returns 0x11 then 0x22 with 3-cycle latency -> m0 served first and receives 0x11, then m1 receives 0x22; the non-owner's rvalid_o/rdata_o stay 0 throughout.
3. Both requesters issue writes back-to-back for 8 transactions -> grant sequence is 0,1,0,1,0,1,0,1; each requester gets 4 acceptances.
4. TIMEOUT_W=4, m1 read with slave never responding -> after 15 WAIT_RD cycles m1_rvalid_o=1, m1_rdata_o=0xDEADBEEF, timeout_o high for exactly 1 cycle; a late s_rvalid_i is ignored.
5. Same setup as 4 but s_iob_rvalid_i with data 0x55 arrives in the expiry cycle -> m1 receives 0x55, timeout_o=0.
6. arstn_i pulsed low during WAIT_RD -> all outputs 0 asynchronously; after release, simultaneous requests grant m0 first. Separately: cke_i low for 20 cycles mid-WAIT_RD with TIMEOUT_W=4 -> no timeout, and the counter resumes from its held value.

Source files
------------

// File: rtl/iob_mem_arbiter_2x1.sv
// ============================================================================
// Module   : iob_mem_arbiter_2x1
// Purpose  : Two-requester round-robin arbiter onto one IOb-native memory port
//            with read-response routing and a read watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iob_mem_arbiter_2x1 #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          TIMEOUT_W = 8,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                cke_i,
  input  logic                m0_iob_valid_i,
  input  logic [ADDR_W-1:0]   m0_iob_addr_i,
  input  logic [DATA_W-1:0]   m0_iob_wdata_i,
  input  logic [DATA_W/8-1:0] m0_iob_wstrb_i,
  output logic                m0_iob_ready_o,
  output logic                m0_iob_rvalid_o,
  output logic [DATA_W-1:0]   m0_iob_rdata_o,
  input  logic                m1_iob_valid_i,
  input  logic [ADDR_W-1:0]   m1_iob_addr_i,
  input  logic [DATA_W-1:0]   m1_iob_wdata_i,
  input  logic [DATA_W/8-1:0] m1_iob_wstrb_i,
  output logic                m1_iob_ready_o,
  output logic                m1_iob_rvalid_o,
  output logic [DATA_W-1:0]   m1_iob_rdata_o,
  output logic                s_iob_valid_o,
  output logic [ADDR_W-1:0]   s_iob_addr_o,
  output logic [DATA_W-1:0]   s_iob_wdata_o,
  output logic [DATA_W/8-1:0] s_iob_wstrb_o,
  input  logic                s_iob_ready_i,
  input  logic                s_iob_rvalid_i,
  input  logic [DATA_W-1:0]   s_iob_rdata_i,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam logic [DATA_W-1:0]    c_ERR_DATA = DATA_W'(ERR_DATA);
  localparam logic [TIMEOUT_W-1:0] c_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic                 w_gnt_valid;
  logic [ADDR_W-1:0]    w_gnt_addr;
  logic [DATA_W-1:0]    w_gnt_wdata;
  logic [DATA_W/8-1:0]  w_gnt_wstrb;

  logic                 w_s_valid;
  logic [ADDR_W-1:0]    w_s_addr;
  logic [DATA_W-1:0]    w_s_wdata;
  logic [DATA_W/8-1:0]  w_s_wstrb;
  logic                 w_ready;
  logic                 w_rvalid;
  logic [DATA_W-1:0]    w_rdata;
  logic                 w_timeout;

  assign w_gnt_valid = grant_q ? m1_iob_valid_i : m0_iob_valid_i;
  assign w_gnt_addr  = grant_q ? m1_iob_addr_i  : m0_iob_addr_i;
  assign w_gnt_wdata = grant_q ? m1_iob_wdata_i : m0_iob_wdata_i;
  assign w_gnt_wstrb = grant_q ? m1_iob_wstrb_i : m0_iob_wstrb_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    w_s_valid    = 1'b0;
    w_s_addr     = '0;
    w_s_wdata    = '0;
    w_s_wstrb    = '0;
    w_ready      = 1'b0;
    w_rvalid     = 1'b0;
    w_rdata      = '0;
    w_timeout    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m0_iob_valid_i || m1_iob_valid_i) begin
          grant_d = (m0_iob_valid_i && m1_iob_valid_i) ? ~last_grant_q : m1_iob_valid_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        w_s_valid = w_gnt_valid;
        w_s_addr  = w_gnt_addr;
        w_s_wdata = w_gnt_wdata;
        w_s_wstrb = w_gnt_wstrb;
        w_ready   = s_iob_ready_i;
        // A requester withdrawing before acceptance forfeits without a priority change.
        if (!w_gnt_valid) begin
          state_d = S_IDLE;
        end else if (s_iob_ready_i) begin
          if (|w_gnt_wstrb) begin
            state_d      = S_IDLE;
            last_grant_d = grant_q;
          end else begin
            state_d = S_WAIT_RD;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT_RD: begin
        if (s_iob_rvalid_i) begin
          w_rvalid     = 1'b1;
          w_rdata      = s_iob_rdata_i;
          state_d      = S_IDLE;
          last_grant_d = grant_q;
        end else if (cnt_q == c_CNT_MAX) begin
          w_rvalid     = 1'b1;
          w_rdata      = c_ERR_DATA;
          w_timeout    = 1'b1;
          state_d      = S_IDLE;
          last_grant_d = grant_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clock-enable low freezes every register and silences all handshakes.
    if (!cke_i) begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      w_s_valid    = 1'b0;
      w_ready      = 1'b0;
      w_rvalid     = 1'b0;
      w_timeout    = 1'b0;
    end
  end

  assign s_iob_valid_o   = w_s_valid;
  assign s_iob_addr_o    = w_s_addr;
  assign s_iob_wdata_o   = w_s_wdata;
  assign s_iob_wstrb_o   = w_s_wstrb;

  assign m0_iob_ready_o  = w_ready  & ~grant_q;
  assign m1_iob_ready_o  = w_ready  &  grant_q;
  assign m0_iob_rvalid_o = w_rvalid & ~grant_q;
  assign m1_iob_rvalid_o = w_rvalid &  grant_q;
  assign m0_iob_rdata_o  = grant_q ? '0 : w_rdata;
  assign m1_iob_rdata_o  = grant_q ? w_rdata : '0;

  assign busy_o          = (state_q != S_IDLE);
  assign timeout_o       = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_iob_mem_arbiter_2x1.sv
// ============================================================================
// Module   : tb_iob_mem_arbiter_2x1
// Purpose  : Directed self-checking bench for iob_mem_arbiter_2x1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iob_mem_arbiter_2x1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              arstn = 1'b1;
  logic              cke = 1'b1;
  logic              m0_valid = 1'b0, m1_valid = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]        m0_wstrb = '0, m1_wstrb = '0;
  logic              m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_ready = 1'b0, s_rvalid = 1'b0;
  logic [DATA_W-1:0] s_rdata = '0;
  logic              busy, tmo;

  int n_checks = 0;
  int n_fail   = 0;

  iob_mem_arbiter_2x1 #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(4), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_i(clk), .arstn_i(arstn), .cke_i(cke),
    .m0_iob_valid_i(m0_valid), .m0_iob_addr_i(m0_addr), .m0_iob_wdata_i(m0_wdata),
    .m0_iob_wstrb_i(m0_wstrb), .m0_iob_ready_o(m0_ready), .m0_iob_rvalid_o(m0_rvalid),
    .m0_iob_rdata_o(m0_rdata),
    .m1_iob_valid_i(m1_valid), .m1_iob_addr_i(m1_addr), .m1_iob_wdata_i(m1_wdata),
    .m1_iob_wstrb_i(m1_wstrb), .m1_iob_ready_o(m1_ready), .m1_iob_rvalid_o(m1_rvalid),
    .m1_iob_rdata_o(m1_rdata),
    .s_iob_valid_o(s_valid), .s_iob_addr_o(s_addr), .s_iob_wdata_o(s_wdata),
    .s_iob_wstrb_o(s_wstrb), .s_iob_ready_i(s_ready), .s_iob_rvalid_i(s_rvalid),
    .s_iob_rdata_i(s_rdata), .busy_o(busy), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 2-3 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    arstn = 1'b0;
    cyc();
    cyc();
    arstn = 1'b1;
  endtask

  task automatic test_reset();
    m0_addr = 32'h1234; m1_addr = 32'h5678; m0_wdata = 32'hFFFF; s_rdata = 32'h99;
    #1 arstn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if ({s_valid, m0_ready, m1_ready, m0_rvalid, m1_rvalid, tmo} !== 6'b0) begin
      n_fail++; $display("FAIL rst_ctrl: got %b want 000000", {s_valid, m0_ready, m1_ready, m0_rvalid, m1_rvalid, tmo}); end
    n_checks++; if ({s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata} !== '0) begin
      n_fail++; $display("FAIL rst_data: got addr %h wdata %h m0 %h m1 %h want 0", s_addr, s_wdata, m0_rdata, m1_rdata); end
    cyc();
    cyc();
    arstn = 1'b1;
    s_rdata = '0;
  endtask

  task automatic test_write();
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hA5A5A5A5; m0_wstrb = 4'hF; s_ready = 1'b1;
    #1;
    n_checks++; if ({s_valid, m0_ready, busy} !== 3'b000) begin
      n_fail++; $display("FAIL wr_idle: got s_valid/ready/busy %b want 000", {s_valid, m0_ready, busy}); end
    cyc();
    #1;
    n_checks++; if ({s_valid, m0_ready, m1_ready, busy} !== 4'b1101) begin
      n_fail++; $display("FAIL wr_req: got s_valid/m0r/m1r/busy %b want 1101", {s_valid, m0_ready, m1_ready, busy}); end
    n_checks++; if ({s_addr, s_wdata, s_wstrb} !== {32'h100, 32'hA5A5A5A5, 4'hF}) begin
      n_fail++; $display("FAIL wr_fwd: got %h %h %h want 100 a5a5a5a5 f", s_addr, s_wdata, s_wstrb); end
    cyc();
    m0_valid = 1'b0;
    #1;
    n_checks++; if ({busy, s_valid} !== 2'b00) begin
      n_fail++; $display("FAIL wr_done: got busy/s_valid %b want 00", {busy, s_valid}); end
  endtask

  task automatic test_read_rr();
    apply_reset();
    m0_valid = 1'b1; m0_addr = 32'h200; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h300; m1_wstrb = 4'h0; s_ready = 1'b1;
    cyc();
    #1;
    n_checks++; if ({m0_ready, m1_ready, s_addr} !== {2'b10, 32'h200}) begin
      n_fail++; $display("FAIL rd_first: got m0r/m1r %b addr %h want 10 200", {m0_ready, m1_ready}, s_addr); end
    cyc();
    m0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      s_rvalid = (k == 2); s_rdata = (k == 2) ? 32'h11 : 32'h0;
      #1;
      n_checks++; if ({m0_rvalid, m1_rvalid, m1_rdata} !== {(k == 2), 1'b0, 32'h0}) begin
        n_fail++; $display("FAIL rd0_route k=%0d: got m0v %b m1v %b m1d %h", k, m0_rvalid, m1_rvalid, m1_rdata); end
      if (k == 2) begin
        n_checks++; if (m0_rdata !== 32'h11) begin n_fail++; $display("FAIL rd0_data: got %h want 11", m0_rdata); end
      end
    end
    cyc();
    s_rvalid = 1'b0; s_rdata = '0;
    cyc();
    #1;
    n_checks++; if ({m0_ready, m1_ready, s_addr} !== {2'b01, 32'h300}) begin
      n_fail++; $display("FAIL rd_second: got m0r/m1r %b addr %h want 01 300", {m0_ready, m1_ready}, s_addr); end
    cyc();
    m1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      s_rvalid = (k == 2); s_rdata = (k == 2) ? 32'h22 : 32'h0;
      #1;
      n_checks++; if ({m1_rvalid, m0_rvalid, m0_rdata} !== {(k == 2), 1'b0, 32'h0}) begin
        n_fail++; $display("FAIL rd1_route k=%0d: got m1v %b m0v %b m0d %h", k, m1_rvalid, m0_rvalid, m0_rdata); end
      if (k == 2) begin
        n_checks++; if (m1_rdata !== 32'h22) begin n_fail++; $display("FAIL rd1_data: got %h want 22", m1_rdata); end
      end
    end
    cyc();
    s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic test_back_to_back();
    int cnt0 = 0;
    int cnt1 = 0;
    m0_valid = 1'b1; m0_addr = 32'hA00; m0_wstrb = 4'hF;
    m1_valid = 1'b1; m1_addr = 32'hB00; m1_wstrb = 4'h3; s_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      cyc();
      #1;
      if (m0_ready) cnt0++;
      if (m1_ready) cnt1++;
      n_checks++; if ({m0_ready, m1_ready} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL b2b_grant t=%0d: got m0r/m1r %b want grant %0d", t, {m0_ready, m1_ready}, t % 2); end
      n_checks++; if (s_addr !== ((t % 2 == 0) ? 32'hA00 : 32'hB00)) begin
        n_fail++; $display("FAIL b2b_addr t=%0d: got %h", t, s_addr); end
      cyc();
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    n_checks++; if (cnt0 !== 4 || cnt1 !== 4) begin
      n_fail++; $display("FAIL b2b_count: got m0 %0d m1 %0d want 4 4", cnt0, cnt1); end
  endtask

  task automatic test_timeout(input bit late_real);
    m1_valid = 1'b1; m1_addr = 32'hC00; m1_wstrb = 4'h0; s_ready = 1'b1;
    cyc();
    #1;
    n_checks++; if (m1_ready !== 1'b1) begin n_fail++; $display("FAIL to_req: got m1_ready %b want 1", m1_ready); end
    cyc();
    m1_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) cyc();
      s_rvalid = late_real && (k == 15); s_rdata = (late_real && k == 15) ? 32'h55 : 32'h0;
      #1;
      n_checks++; if ({m1_rvalid, m0_rvalid, tmo} !== {(k == 15), 1'b0, (!late_real && k == 15)}) begin
        n_fail++; $display("FAIL to_wait k=%0d: got m1v/m0v/tmo %b", k, {m1_rvalid, m0_rvalid, tmo}); end
      if (k == 15) begin
        n_checks++; if (m1_rdata !== (late_real ? 32'h55 : 32'hDEADBEEF)) begin
          n_fail++; $display("FAIL to_data: got %h want %h", m1_rdata, late_real ? 32'h55 : 32'hDEADBEEF); end
      end
    end
    cyc();
    s_rvalid = 1'b1; s_rdata = 32'h77;
    #1;
    n_checks++; if ({m1_rvalid, m1_rdata, tmo, busy} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL to_late: got m1v %b m1d %h tmo %b busy %b want all 0", m1_rvalid, m1_rdata, tmo, busy); end
    cyc();
    s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic test_async_reset();
    m0_valid = 1'b1; m0_addr = 32'hD00; m0_wstrb = 4'h0; s_ready = 1'b1;
    cyc();
    cyc();
    m0_valid = 1'b0;
    cyc();
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_wait: got busy %b want 1", busy); end
    arstn = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h66;
    #1;
    n_checks++; if ({busy, s_valid, m0_ready, m1_ready, m0_rvalid, m1_rvalid, tmo, m0_rdata} !== '0) begin
      n_fail++; $display("FAIL ar_async: got busy %b m0v %b m0d %h want 0", busy, m0_rvalid, m0_rdata); end
    cyc();
    s_rvalid = 1'b0; s_rdata = '0;
    arstn = 1'b1;
    m0_valid = 1'b1; m0_wstrb = 4'hF; m1_valid = 1'b1; m1_wstrb = 4'hF;
    cyc();
    #1;
    n_checks++; if ({m0_ready, m1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL ar_prio: got m0r/m1r %b want 10", {m0_ready, m1_ready}); end
    cyc();
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic test_cke();
    int frozen_bad = 0;
    m0_valid = 1'b1; m0_addr = 32'hE00; m0_wstrb = 4'h0; s_ready = 1'b1;
    cyc();
    cyc();
    m0_valid = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    cke = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      #1;
      if (tmo !== 1'b0 || m0_rvalid !== 1'b0 || busy !== 1'b1 || s_valid !== 1'b0) frozen_bad++;
    end
    n_checks++; if (frozen_bad !== 0) begin
      n_fail++; $display("FAIL cke_hold: got %0d bad frozen cycles want 0", frozen_bad); end
    cyc();
    cke = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) cyc();
      #1;
      n_checks++; if ({tmo, m0_rvalid} !== {(k == 10), (k == 10)}) begin
        n_fail++; $display("FAIL cke_resume k=%0d: got tmo/m0v %b want %b", k, {tmo, m0_rvalid}, {(k == 10), (k == 10)}); end
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_rr();
    test_back_to_back();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_async_reset();
    test_cke();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
